// File: rtl/timebase_if.sv
// rtl/timebase_if.sv - timebase bus: time load/readout, latch channels and LED controls
interface timebase_if #(
    parameter int TIME_BITS = 64,
    parameter int NLATCH    = 2,
    parameter int NLEDS     = 8
);
    logic [TIME_BITS-1:0]        time_set;
    logic                        time_set_en;
    logic [TIME_BITS-1:0]        time_out;
    logic [NLATCH-1:0]           latch_in;
    logic [NLATCH-1:0]           latch_arm;
    logic [NLATCH-1:0]           latch_ack;
    logic [NLATCH-1:0]           latch_valid;
    logic [NLATCH-1:0]           latch_overrun;
    logic [NLATCH*TIME_BITS-1:0] latch_time;
    logic [1:0]                  led_mode;
    logic [NLEDS-1:0]            led_pattern;
    logic [NLEDS-1:0]            leds;

    modport master (
        output time_set, time_set_en, latch_in, latch_arm, latch_ack, led_mode, led_pattern,
        input  time_out, latch_valid, latch_overrun, latch_time, leds
    );

    modport slave (
        input  time_set, time_set_en, latch_in, latch_arm, latch_ack, led_mode, led_pattern,
        output time_out, latch_valid, latch_overrun, latch_time, leds
    );
endinterface

// File: rtl/timebase.sv
// rtl/timebase.sv - free-running system time with external time-latch channels and status LEDs
module timebase #(
    parameter int TIME_BITS   = 64,
    parameter int NLATCH      = 2,
    parameter int SYNC_STAGES = 2,
    parameter int NLEDS       = 8,
    parameter int LED_SHIFT   = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    timebase_if.slave  bus
);
    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_ARMED    = 2'd1;
    localparam logic [1:0] ST_CAPTURED = 2'd2;

    localparam logic [TIME_BITS-1:0] LP_ONE  = TIME_BITS'(1);
    // Pin-to-detect latency: SYNC_STAGES synchroniser flops, then the registered edge pulse
    localparam logic [TIME_BITS-1:0] LP_COMP = TIME_BITS'(SYNC_STAGES + 1);
    localparam logic [NLEDS-1:0]     LP_LED1 = NLEDS'(1);

    logic [TIME_BITS-1:0]   r_time;
    logic [TIME_BITS-1:0]   w_time_next;
    logic                   w_tick;

    logic [SYNC_STAGES-1:0] r_sync  [NLATCH];
    logic [NLATCH-1:0]      r_hist;
    logic [NLATCH-1:0]      r_edge;
    logic [1:0]             r_state [NLATCH];
    logic [NLATCH-1:0]      r_valid;
    logic [NLATCH-1:0]      r_overrun;
    logic [TIME_BITS-1:0]   r_ltime [NLATCH];

    logic [NLEDS-1:0]       r_leds;
    logic [1:0]             r_mode_prev;

    // Next counter value: a load replaces the increment for that cycle
    always_comb begin
        w_time_next = bus.time_set_en ? bus.time_set : (r_time + LP_ONE);
        w_tick      = (w_time_next[LED_SHIFT-1:0] == '0);
    end

    // System time counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_time <= '0;
        end else begin
            r_time <= w_time_next;
        end
    end

    // Per-channel synchroniser, edge detector and capture FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NLATCH; i++) begin
                r_sync[i]  <= '0;
                r_state[i] <= ST_IDLE;
                r_ltime[i] <= '0;
            end
            r_hist    <= '0;
            r_edge    <= '0;
            r_valid   <= '0;
            r_overrun <= '0;
        end else begin
            for (int i = 0; i < NLATCH; i++) begin
                r_sync[i] <= {r_sync[i][SYNC_STAGES-2:0], bus.latch_in[i]};
                r_hist[i] <= r_sync[i][SYNC_STAGES-1];
                r_edge[i] <= r_sync[i][SYNC_STAGES-1] & ~r_hist[i];

                case (r_state[i])
                    ST_IDLE: begin
                        // An edge coinciding with the arm pulse is deliberately not captured
                        if (bus.latch_arm[i]) begin
                            r_state[i] <= ST_ARMED;
                        end
                    end
                    ST_ARMED: begin
                        if (r_edge[i]) begin
                            r_state[i] <= ST_CAPTURED;
                            // r_time is the pre-load value even if a load is in flight
                            r_ltime[i] <= r_time - LP_COMP;
                            r_valid[i] <= 1'b1;
                        end
                    end
                    ST_CAPTURED: begin
                        if (bus.latch_ack[i]) begin
                            r_state[i]   <= bus.latch_arm[i] ? ST_ARMED : ST_IDLE;
                            r_valid[i]   <= 1'b0;
                            r_overrun[i] <= 1'b0;
                        end else if (r_edge[i]) begin
                            r_overrun[i] <= 1'b1;
                        end
                    end
                    default: begin
                        r_state[i] <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // LED driver; the tick is taken from the next time value so leds change with time_out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_leds      <= LP_LED1;
            r_mode_prev <= 2'd0;
        end else begin
            r_mode_prev <= bus.led_mode;
            case (bus.led_mode)
                2'd0: begin
                    if (r_mode_prev != 2'd0) begin
                        r_leds <= LP_LED1;
                    end else if (w_tick) begin
                        r_leds <= {r_leds[NLEDS-2:0], r_leds[NLEDS-1]};
                    end
                end
                2'd1: begin
                    r_leds <= '1;
                end
                2'd2: begin
                    if (r_mode_prev != 2'd2) begin
                        r_leds <= '0;
                    end else if (w_tick) begin
                        r_leds <= ~r_leds;
                    end
                end
                default: begin
                    r_leds <= bus.led_pattern;
                end
            endcase
        end
    end

    // Output mapping
    always_comb begin
        bus.time_out      = r_time;
        bus.latch_valid   = r_valid;
        bus.latch_overrun = r_overrun;
        bus.leds          = r_leds;
        for (int i = 0; i < NLATCH; i++) begin
            bus.latch_time[i*TIME_BITS +: TIME_BITS] = r_ltime[i];
        end
    end
endmodule

// File: doc/timebase.md
TIMEBASE -- requirements
Module: timebase

Interface
REQ-001 Parameter TIME_BITS, default 64: width of the system time counter.
REQ-002 Parameter NLATCH, default 2: number of independent time-latch channels.
REQ-003 Parameter SYNC_STAGES, default 2, minimum 2: synchroniser flops per latch input.
REQ-004 Parameter NLEDS, default 8: number of status LED outputs.
REQ-005 Parameter LED_SHIFT, default 22: an LED tick occurs when time_out[LED_SHIFT-1:0]==0.
REQ-006 clk  in  1  single system clock; all logic is on its rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 time_set  in  TIME_BITS  load value for the counter.
REQ-009 time_set_en  in  1  load strobe, one cycle.
REQ-010 time_out  out  TIME_BITS  current system time.
REQ-011 latch_in  in  NLATCH  asynchronous external latch pins.
REQ-012 latch_arm  in  NLATCH  per-channel arm pulse.
REQ-013 latch_ack  in  NLATCH  per-channel consume pulse.
REQ-014 latch_valid  out  NLATCH  per-channel captured-time-valid flag.
REQ-015 latch_overrun  out  NLATCH  per-channel flag: edge seen while the previous capture was unconsumed.
REQ-016 latch_time  out  NLATCH*TIME_BITS  captured times; channel i occupies bits [i*TIME_BITS +: TIME_BITS].
REQ-017 led_mode  in  2  0 chase, 1 all on, 2 blink, 3 pattern.
REQ-018 led_pattern  in  NLEDS  direct LED value for mode 3.
REQ-019 leds  out  NLEDS  registered LED outputs.

Function
REQ-020 Counter: time_out increments by 1 per cycle and wraps from all-ones to 0.
REQ-021 time_set_en high: on the next cycle time_out==time_set, with no increment in that cycle.
REQ-022 Each latch_in bit passes through SYNC_STAGES flops plus one history flop; a rising edge is detected when synced==1 and history==0.
REQ-023 Edge detection is a single-cycle event per rising edge; pulses shorter than one clk period are not guaranteed to be detected.
REQ-024 Per-channel FSM has three states: IDLE, ARMED, CAPTURED.
REQ-025 IDLE: latch_arm -> ARMED; an edge in IDLE is ignored.
REQ-026 ARMED: edge -> CAPTURED, latch_time loaded, latch_valid set on the following cycle; latch_arm has no effect.
REQ-027 Edge and latch_arm in the same cycle in IDLE: the channel goes to ARMED only; that edge is not captured.
REQ-028 CAPTURED: an edge sets latch_overrun and latch_time is not overwritten.
REQ-029 CAPTURED with latch_ack: go to IDLE and clear latch_valid and latch_overrun.
REQ-030 CAPTURED with latch_ack and latch_arm in the same cycle: go to ARMED.
REQ-031 latch_ack in IDLE or ARMED is ignored.
REQ-032 Captured value = (time_out in the detect cycle) - (SYNC_STAGES+1), modulo 2^TIME_BITS.
REQ-033 The compensation equals the pin-to-detect latency, so a bench raising the pin just before edge k reads back the time_out value shown during cycle k.
REQ-034 When time_set_en and a detect occur in the same cycle, the capture uses the pre-load time_out.
REQ-035 LED tick = (time_out[LED_SHIFT-1:0]==0); ticks follow counter loads.
REQ-036 Mode 0: on each tick, leds rotate left by one (MSB wraps to LSB).
REQ-037 Mode 1: leds are all ones.
REQ-038 Mode 2: on each tick, leds toggle between all ones and all zeros.
REQ-039 Mode 3: leds = led_pattern, registered with one-cycle latency.
REQ-040 On entry to mode 0 or 2 from any other mode, leds load 1 (one-hot LSB) or all zeros respectively, then follow ticks.

Reset
REQ-041 rst_n low asynchronously forces: time_out=0, leds=1 (LSB only), all FSMs IDLE, latch_valid=0, latch_overrun=0, latch_time=0, synchroniser and history flops=0.
REQ-042 A reset mid-capture discards the capture; no edge is reported on release unless a new 0->1 transition is synchronised.
REQ-043 Outputs remain at their reset values until the first rising clk edge after rst_n deasserts.

Verification
REQ-044 Release reset, run 10 cycles -> time_out==10, leds==1, latch_valid==0.
REQ-045 Load time_set=2^TIME_BITS-2 -> the following cycles read all-ones-minus-1, all-ones, 0, 1 (wrap).
REQ-046 Arm ch0, hold time_out at 1000 during cycle k, raise latch_in[0] just before edge k -> latch_valid[0]=1 and latch_time ch0 == 1000 (SYNC_STAGES=2).
REQ-047 Capture ch1, second edge before ack -> latch_overrun[1]=1 and first time retained; ack with arm in the same cycle -> valid=0, overrun=0, channel ARMED.
REQ-048 LED_SHIFT=4, mode 0 -> leds rotate 1,2,4,... every 16 cycles and wrap 0x80->0x01; switch to mode 2 -> all zeros, then 0xFF at the next tick.
REQ-049 Assert rst_n low while ch0 is ARMED with the pin high -> after release, valid stays 0 until the pin drops, the channel is re-armed and a new rising edge is applied.
